sha256_digest_unloader: RTL and testbench

Consumer side of the SHA-256 working-variable bank. After each 64-round compression it captures the final working variables a..h and adds them word-wise, mod 2^32, into the chaining hash H0..H7. It holds the chaining hash for the next block's initial load. On the last block it streams the 256-bit digest out as eight 32-bit words over a valid/ready handshake.

---
 rtl/sha256_digest_unloader_if.sv | 25 ++
 rtl/sha256_digest_unloader.sv | 111 +++++++++++
 tb/tb_sha256_digest_unloader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_digest_unloader_if.sv
// Block-result input and digest stream bundle between the SHA-256 round bank,
// the chaining-hash accumulator and the downstream digest consumer.
interface sha256_digest_unloader_if;
  logic         init_hash;
  logic         block_done;
  logic         last_block;
  logic [255:0] work_in;
  logic [255:0] hash_state;
  logic         busy;
  logic         overrun;
  logic         dout_valid;
  logic         dout_ready;
  logic [31:0]  dout_data;
  logic         dout_last;

  modport master (
    output init_hash, block_done, last_block, work_in, dout_ready,
    input  hash_state, busy, overrun, dout_valid, dout_data, dout_last
  );

  modport slave (
    input  init_hash, block_done, last_block, work_in, dout_ready,
    output hash_state, busy, overrun, dout_valid, dout_data, dout_last
  );
endinterface

// File: rtl/sha256_digest_unloader.sv
// Adds each block's final working variables into the chaining hash and
// streams the 256-bit digest as eight 32-bit words after the last block.
//
// state    | meaning
// S_IDLE   | waiting for block_done; init_hash reloads IV
// S_ACCUM  | one cycle: H += captured working variables
// S_STREAM | presenting H[idx] on the valid/ready stream
module sha256_digest_unloader #(
  parameter logic [255:0] IV = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19
) (
  input logic clk,
  input logic rst,
  sha256_digest_unloader_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_STREAM} state_e;

  state_e       state_q;
  logic [255:0] h_q;
  logic [255:0] w_q;
  logic         last_q;
  logic [2:0]   idx_q;
  logic         busy_q;
  logic         overrun_q;
  logic         valid_q;
  logic         dlast_q;
  logic [31:0]  data_q;

  logic [255:0] h_d;
  logic [2:0]   idx_d;
  logic [31:0]  word_d;

  // Independent 32-bit lanes: carries never cross word boundaries.
  always_comb begin
    h_d = '0;
    for (int i = 0; i < 8; i++) begin
      h_d[32*i +: 32] = h_q[32*i +: 32] + w_q[32*i +: 32];
    end
  end

  assign idx_d  = idx_q + 3'd1;
  assign word_d = h_q[8'd255 - {idx_d, 5'b00000} -: 32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      h_q       <= IV;
      w_q       <= '0;
      last_q    <= 1'b0;
      idx_q     <= 3'd0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      dlast_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      overrun_q <= bus.block_done && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (bus.init_hash) begin
            h_q <= IV;
          end else if (bus.block_done) begin
            w_q     <= bus.work_in;
            last_q  <= bus.last_block;
            busy_q  <= 1'b1;
            state_q <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          h_q <= h_d;
          if (last_q) begin
            // First beat is loaded from the freshly summed H0.
            idx_q   <= 3'd0;
            data_q  <= h_d[255:224];
            valid_q <= 1'b1;
            dlast_q <= 1'b0;
            state_q <= S_STREAM;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_STREAM: begin
          if (valid_q && bus.dout_ready) begin
            if (idx_q == 3'd7) begin
              idx_q   <= 3'd0;
              data_q  <= '0;
              valid_q <= 1'b0;
              dlast_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= idx_d;
              data_q  <= word_d;
              dlast_q <= (idx_d == 3'd7);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.hash_state = h_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.dout_valid = valid_q;
  assign bus.dout_data  = data_q;
  assign bus.dout_last  = dlast_q;

endmodule

// File: tb/tb_sha256_digest_unloader.sv
// Bench for sha256_digest_unloader: queue-based reference model checked every
// cycle, directed known-answer cases, then randomized traffic.
module tb_sha256_digest_unloader;

  localparam logic [255:0] IV     = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
  localparam logic [255:0] ABC_W  = 256'h506E3058_D39A2165_04D24D6C_B85E2CE9_5EF50F24_FB121210_948D25B6_961F4894;
  localparam logic [255:0] ABC_D  = 256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;
  localparam logic [255:0] ALL_F  = {8{32'hFFFFFFFF}};
  localparam logic [255:0] ALL_1  = {8{32'h00000001}};
  localparam logic [255:0] IV_M1  = 256'h6A09E666_BB67AE84_3C6EF371_A54FF539_510E527E_9B05688B_1F83D9AA_5BE0CD18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sha256_digest_unloader_if bus ();

  sha256_digest_unloader #(.IV(IV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [255:0] v, input int i);
    return v[255 - 32*i -: 32];
  endfunction

  // Reference model: chaining hash as eight words, a pending accumulation,
  // and a queue of digest words still to be delivered.
  logic [31:0] mh [8];
  logic [31:0] mw [8];
  bit          m_last;
  bit          m_accum;
  logic [31:0] mq [$];
  bit          exp_ovr;

  logic [31:0] beats [$];
  int          stream_cyc;
  int          ovr_cnt;
  bit          v_s;
  logic [31:0] d_s;

  function automatic logic [255:0] model_hash();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = mh[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mh[i] = word_of(IV, i);
    mq.delete();
    m_accum = 1'b0;
    m_last  = 1'b0;
    exp_ovr = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
      v_s = 1'b0;
    end else begin
      bit busy_m;
      if (v_s && bus.dout_ready) beats.push_back(d_s);
      if (v_s) stream_cyc++;
      busy_m  = m_accum || (mq.size() > 0);
      exp_ovr = bus.block_done && busy_m;
      if (m_accum) begin
        for (int i = 0; i < 8; i++) mh[i] = mh[i] + mw[i];
        if (m_last) for (int i = 0; i < 8; i++) mq.push_back(mh[i]);
        m_accum = 1'b0;
      end else if (mq.size() > 0) begin
        if (bus.dout_ready) void'(mq.pop_front());
      end else if (bus.init_hash) begin
        for (int i = 0; i < 8; i++) mh[i] = word_of(IV, i);
      end else if (bus.block_done) begin
        for (int i = 0; i < 8; i++) mw[i] = word_of(bus.work_in, i);
        m_last  = bus.last_block;
        m_accum = 1'b1;
      end
    end
    #1;
    if (rst) begin
      chk("hash_state", bus.hash_state, model_hash());
      chk("busy", 256'(bus.busy), 256'(m_accum || (mq.size() > 0)));
      chk("overrun", 256'(bus.overrun), 256'(exp_ovr));
      chk("dout_valid", 256'(bus.dout_valid), 256'(mq.size() > 0));
      chk("dout_last", 256'(bus.dout_last), 256'(mq.size() == 1));
      if (mq.size() > 0) chk("dout_data", 256'(bus.dout_data), 256'(mq[0]));
      if (bus.overrun) ovr_cnt++;
      v_s = bus.dout_valid;
      d_s = bus.dout_data;
    end
  end

  task automatic do_block(input logic [255:0] w, input logic last);
    @(negedge clk);
    bus.block_done = 1'b1;
    bus.last_block = last;
    bus.work_in    = w;
    @(negedge clk);
    bus.block_done = 1'b0;
    bus.last_block = 1'b0;
  endtask

  task automatic do_init();
    @(negedge clk);
    bus.init_hash = 1'b1;
    @(negedge clk);
    bus.init_hash = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 256'(bus.busy), 256'(0));
  endtask

  task automatic wait_beats(input int cnt, input int budget);
    int n = 0;
    while (beats.size() < cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_beats_timeout", 256'(beats.size() >= cnt), 256'(1));
  endtask

  task automatic chk_beats(input string name, input logic [255:0] exp);
    chk({name, "_count"}, 256'(beats.size()), 256'(8));
    for (int i = 0; i < 8 && i < beats.size(); i++) chk(name, 256'(beats[i]), 256'(word_of(exp, i)));
  endtask

  initial begin
    logic [255:0] rw;
    bus.init_hash  = 1'b0;
    bus.block_done = 1'b0;
    bus.last_block = 1'b0;
    bus.work_in    = '0;
    bus.dout_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("reset_hash", bus.hash_state, IV);
    chk("reset_busy", 256'(bus.busy), 256'(0));
    chk("reset_overrun", 256'(bus.overrun), 256'(0));
    chk("reset_valid", 256'(bus.dout_valid), 256'(0));
    chk("reset_last", 256'(bus.dout_last), 256'(0));
    chk("reset_data", 256'(bus.dout_data), 256'(0));

    // "abc" known answer, ready held high
    bus.dout_ready = 1'b1;
    beats.delete();
    stream_cyc = 0;
    do_block(ABC_W, 1'b1);
    wait_idle(40);
    chk_beats("abc_beat", ABC_D);
    chk("abc_stream_cycles", 256'(stream_cyc), 256'(8));
    chk("abc_model_hash", model_hash(), ABC_D);
    chk("abc_hash_state", bus.hash_state, ABC_D);

    // Backpressure: three stall cycles on beat index 3
    do_init();
    beats.delete();
    stream_cyc = 0;
    do_block(ABC_W, 1'b1);
    wait_beats(3, 20);
    bus.dout_ready = 1'b0;
    chk("bp_hold_data", 256'(bus.dout_data), 256'(32'h5DAE2223));
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", 256'(bus.dout_data), 256'(32'h5DAE2223));
      chk("bp_hold_valid", 256'(bus.dout_valid), 256'(1));
    end
    bus.dout_ready = 1'b1;
    wait_idle(40);
    chk_beats("bp_beat", ABC_D);
    chk("bp_stream_cycles", 256'(stream_cyc), 256'(11));

    // Multi-block with per-word wrap
    do_init();
    beats.delete();
    stream_cyc = 0;
    do_block(ALL_F, 1'b0);
    wait_idle(10);
    chk("wrap_hash", bus.hash_state, IV_M1);
    chk("wrap_no_valid", 256'(stream_cyc), 256'(0));
    do_block(ALL_1, 1'b1);
    wait_idle(40);
    chk_beats("wrap_beat", IV);

    // Overrun during STREAM
    do_init();
    beats.delete();
    ovr_cnt = 0;
    do_block(ABC_W, 1'b1);
    @(negedge clk);
    bus.block_done = 1'b1;
    bus.work_in    = ALL_F;
    @(negedge clk);
    bus.block_done = 1'b0;
    wait_idle(40);
    chk_beats("ovr_beat", ABC_D);
    chk("ovr_pulses", 256'(ovr_cnt), 256'(1));

    // init_hash beats block_done in IDLE
    do_block(ALL_F, 1'b0);
    wait_idle(10);
    ovr_cnt = 0;
    @(negedge clk);
    bus.init_hash  = 1'b1;
    bus.block_done = 1'b1;
    bus.work_in    = ALL_F;
    @(negedge clk);
    bus.init_hash  = 1'b0;
    bus.block_done = 1'b0;
    chk("prio_busy", 256'(bus.busy), 256'(0));
    chk("prio_hash", bus.hash_state, IV);
    @(negedge clk);
    chk("prio_hash_later", bus.hash_state, IV);
    chk("prio_no_overrun", 256'(ovr_cnt), 256'(0));

    // Asynchronous reset mid-stream, then a fresh stream
    beats.delete();
    do_block(ABC_W, 1'b1);
    wait_beats(4, 20);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_valid", 256'(bus.dout_valid), 256'(0));
    chk("rst_mid_hash", bus.hash_state, IV);
    chk("rst_mid_busy", 256'(bus.busy), 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    beats.delete();
    do_block(ABC_W, 1'b1);
    wait_idle(40);
    chk_beats("rst_after_beat", ABC_D);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) rw[255 - 32*i -: 32] = $urandom;
      bus.work_in    = rw;
      bus.block_done = ($urandom_range(0, 3) == 0);
      bus.last_block = ($urandom_range(0, 2) == 0);
      bus.init_hash  = ($urandom_range(0, 9) == 0);
      bus.dout_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.block_done = 1'b0;
    bus.init_hash  = 1'b0;
    bus.dout_ready = 1'b1;
    wait_idle(60);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
